// File: rtl/forward_stall_unit_if.sv
// Bundle between the pipeline control and the forwarding/stall unit.
// The master modport drives pipeline state and the slave modport returns the forwarding decisions.
interface forward_stall_unit_if #(
  parameter int unsigned AW             = 5,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned NUM_FWD_STAGES = 2
);
  localparam int unsigned SELW = $clog2(NUM_FWD_STAGES + 2);

  logic [NUM_SRC*AW-1:0]        rs_adr_r;
  logic [NUM_SRC-1:0]           rs_used_r;
  logic [AW-1:0]                rd_adr_r;
  logic                         reg_write_r;
  logic [NUM_FWD_STAGES*AW-1:0] rd_adr_s;
  logic [NUM_FWD_STAGES-1:0]    reg_write_s;
  logic [NUM_FWD_STAGES-1:0]    mem_en_s;
  logic                         long_issue_c;
  logic                         long_done;
  logic [AW-1:0]                long_done_adr;
  logic                         kill_r;
  logic [NUM_SRC*SELW-1:0]      forward_sel_c;
  logic                         stall_pc;
  logic                         stall_ir;
  logic                         flush_rc;
  logic [(1<<AW)-1:0]           busy;
  logic [15:0]                  stall_cycles;

  modport master (
    output rs_adr_r, rs_used_r, rd_adr_r, reg_write_r, rd_adr_s, reg_write_s, mem_en_s,
           long_issue_c, long_done, long_done_adr, kill_r,
    input  forward_sel_c, stall_pc, stall_ir, flush_rc, busy, stall_cycles
  );

  modport slave (
    input  rs_adr_r, rs_used_r, rd_adr_r, reg_write_r, rd_adr_s, reg_write_s, mem_en_s,
           long_issue_c, long_done, long_done_adr, kill_r,
    output forward_sel_c, stall_pc, stall_ir, flush_rc, busy, stall_cycles
  );
endinterface

// File: rtl/forward_stall_unit.sv
// Operand forwarding select, load-use / scoreboard / WAW hazard detection and a
// busy-register scoreboard for a multi-cycle functional unit.
module forward_stall_unit #(
  parameter int unsigned AW             = 5,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned LOAD_LATENCY   = 1
) (
  input logic                clk_i,
  input logic                rst_ni,
  forward_stall_unit_if.slave bus_io
);
  localparam int unsigned SELW = $clog2(NUM_FWD_STAGES + 2);
  localparam int unsigned NREG = 1 << AW;

  logic [NUM_SRC*SELW-1:0] sel_raw, sel_d, sel_q;
  logic [NREG-1:0]         busy_d, busy_q;
  logic [15:0]             cycles_d, cycles_q;
  logic                    hazard, waw, stall;

  always_comb begin
    logic [AW-1:0] src;
    logic          found;
    sel_raw = '0;
    hazard  = 1'b0;
    src     = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src   = bus_io.rs_adr_r[i*AW +: AW];
      found = 1'b0;
      if (bus_io.rs_used_r[i] && (src != '0)) begin
        // Nearest producing stage wins; a load too young to forward stalls instead.
        for (int unsigned j = 0; j < NUM_FWD_STAGES; j++) begin
          if (!found && bus_io.reg_write_s[j] && (bus_io.rd_adr_s[j*AW +: AW] != '0) &&
              (bus_io.rd_adr_s[j*AW +: AW] == src)) begin
            found = 1'b1;
            if (bus_io.mem_en_s[j] && (j < LOAD_LATENCY)) begin
              hazard = 1'b1;
            end else begin
              sel_raw[i*SELW +: SELW] = SELW'(j + 1);
            end
          end
        end
        if (!found) begin
          if (bus_io.long_done && (bus_io.long_done_adr == src)) begin
            sel_raw[i*SELW +: SELW] = SELW'(NUM_FWD_STAGES + 1);
          end else if (busy_q[src]) begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

  // A pending long op that retires this very cycle no longer blocks the younger writer.
  assign waw = bus_io.reg_write_r && (bus_io.rd_adr_r != '0) && busy_q[bus_io.rd_adr_r] &&
               !(bus_io.long_done && (bus_io.long_done_adr == bus_io.rd_adr_r));

  assign stall = (hazard || waw) && !bus_io.kill_r && rst_ni;

  always_comb begin
    sel_d = (stall || bus_io.kill_r) ? '0 : sel_raw;

    busy_d = busy_q;
    if (bus_io.long_done) begin
      busy_d[bus_io.long_done_adr] = 1'b0;
    end
    // Set after clear: a same-cycle clear belongs to the older op.
    if (bus_io.long_issue_c && bus_io.reg_write_s[0] && (bus_io.rd_adr_s[0 +: AW] != '0)) begin
      busy_d[bus_io.rd_adr_s[0 +: AW]] = 1'b1;
    end
    busy_d[0] = 1'b0;

    cycles_d = cycles_q;
    if (stall && (cycles_q != 16'hFFFF)) begin
      cycles_d = cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q    <= '0;
      busy_q   <= '0;
      cycles_q <= '0;
    end else begin
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus_io.forward_sel_c = sel_q;
  assign bus_io.busy          = busy_q;
  assign bus_io.stall_cycles  = cycles_q;
  assign bus_io.stall_pc      = stall;
  assign bus_io.stall_ir      = stall;
  assign bus_io.flush_rc      = stall;
endmodule
